// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing over a
// shared memory port, datapath enables/selects, and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE,
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC
  } iclass_t;

  state_t            r_state;
  iclass_t           r_class;
  iclass_t           w_dec_class;
  logic [CNT_W-1:0]  r_instret;
  logic              w_unused_funct3;

  // funct3 only matters to the ALU decoder; sequencing never looks at it.
  assign w_unused_funct3 = ^funct3;
  assign instret         = r_instret;

  always_comb begin
    case (opcode)
      7'b0110011: w_dec_class = C_R;
      7'b0010011: w_dec_class = C_I;
      7'b0000011: w_dec_class = C_LOAD;
      7'b0100011: w_dec_class = C_STORE;
      7'b1100011: w_dec_class = C_BRANCH;
      7'b1101111: w_dec_class = C_JAL;
      7'b1100111: w_dec_class = C_JALR;
      7'b0110111: w_dec_class = C_LUI;
      7'b0010111: w_dec_class = C_AUIPC;
      default:    w_dec_class = C_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_class   <= C_NONE;
      r_instret <= '0;
    end else begin
      if (pc_write) r_instret <= r_instret + 1'b1;
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_class <= w_dec_class;
          r_state <= (w_dec_class == C_NONE) ? S_TRAP : S_EXECUTE;
        end
        S_EXECUTE: begin
          case (r_class)
            C_BRANCH:        r_state <= S_FETCH;
            C_LOAD, C_STORE: r_state <= S_MEM;
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) r_state <= (r_class == C_LOAD) ? S_WB : S_FETCH;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs are gated by reset directly so a mid-instruction reset drops them at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    wb_sel    = 2'b00;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'b00;
    illegal   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXECUTE: begin
          case (r_class)
            C_R: alu_op = 2'b10;
            C_I: begin
              alu_op    = 2'b10;
              alu_src_b = 1'b1;
            end
            C_LOAD, C_STORE, C_JALR: alu_src_b = 1'b1;
            C_AUIPC, C_JAL: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
            end
            C_BRANCH: begin
              alu_op   = 2'b01;
              pc_write = 1'b1;
              pc_sel   = branch_taken ? 2'b01 : 2'b00;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (r_class == C_STORE);
          pc_write = mem_ready && (r_class == C_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          case (r_class)
            C_LOAD:       wb_sel = 2'b01;
            C_JAL, C_JALR: begin
              wb_sel = 2'b10;
              pc_sel = 2'b10;
            end
            C_LUI:        wb_sel = 2'b11;
            default:      wb_sel = 2'b00;
          endcase
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM that sequences the RV32I datapath: instruction fetch, decode, execute, memory access and register writeback over several clocks, sharing one memory port between instruction and data accesses. It consumes the decoded `opcode`/`funct3` fields from the instruction-field parser (fed from the instruction register) and the ALU compare flag. It drives every datapath enable and mux select, and keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12], passed through for branch/ALU decode
- branch_taken  in  1  ALU compare result for the current branch
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until `mem_ready`
- mem_we  out  1  write request, valid with `mem_req`
- addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- ir_write  out  1  load the instruction register
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 compare, 10 funct-decoded
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate
- reg_write  out  1  register-file write enable
- pc_write  out  1  PC update enable
- pc_sel  out  2  00 PC+4, 01 branch target, 10 ALU result
- illegal  out  1  sticky illegal-opcode flag
- instret  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- Outputs are combinational from state, the class register, `mem_ready` and `branch_taken`. Any output not listed for a state is 0.
- FETCH: `mem_req`=1, `addr_sel`=0. If `mem_ready`, `ir_write`=1 and next state is DECODE. Otherwise stay in FETCH.
- DECODE: latch the instruction class from `opcode` into the class register.
  - Classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode: next state is TRAP. Otherwise next state is EXECUTE.
- EXECUTE, per class:
  - R: `alu_op`=10, `alu_src_b`=0.
  - I: `alu_op`=10, `alu_src_b`=1.
  - LOAD/STORE/JALR: `alu_op`=00, `alu_src_b`=1.
  - AUIPC/JAL: `alu_op`=00, `alu_src_a`=1, `alu_src_b`=1.
  - BRANCH: `alu_op`=01, `alu_src_b`=0, `pc_write`=1, `pc_sel` = `branch_taken` ? 01 : 00. Next state is FETCH (branch retires here).
  - LOAD/STORE: next state is MEM.
  - All other classes: next state is WB.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=1 for STORE. Stay until `mem_ready`, then:
  - LOAD: next state is WB.
  - STORE: `pc_write`=1, `pc_sel`=00, next state is FETCH (store retires here).
- WB: `reg_write`=1, `pc_write`=1, next state is FETCH.
  - `wb_sel`: R/I/AUIPC → 00, LOAD → 01, JAL/JALR → 10, LUI → 11.
  - `pc_sel`: JAL/JALR → 10, otherwise 00.
- TRAP: all outputs 0 except `illegal`=1. No exit except reset.
- `instret` increments by 1 on every cycle with `pc_write`=1. It wraps modulo 2^CNT_W.
- `funct3` is not used for sequencing. Branch condition evaluation is external.

## Timing
- Reset (asynchronous) forces state to FETCH, class register to 0, `illegal`=0 and `instret`=0.
- While `reset`=1, all outputs are 0, including `mem_req`. First `mem_req` is in the first cycle after `reset` deasserts.
- Cycles per instruction with zero-wait memory (`mem_ready`=1 in the request cycle):
  - BRANCH: 3
  - R, I, LUI, AUIPC, JAL, JALR, STORE: 4
  - LOAD: 5
- Each cycle `mem_ready`=0 during FETCH or MEM adds exactly one cycle. `mem_req`, `mem_we` and `addr_sel` hold stable throughout.
- `mem_ready` outside FETCH/MEM is ignored.
- `ir_write` asserts only in the FETCH cycle where `mem_ready`=1. `opcode` must be stable from DECODE onward.
- `pc_write` asserts exactly once per retired instruction. `reg_write` asserts exactly once per non-branch, non-store instruction.
- Reset asserted mid-instruction (e.g. in MEM): outputs go to 0 immediately, the memory request is abandoned, and no counter update occurs.
- Counter wrap: `instret` = 2^CNT_W − 1 plus one retire gives 0. No flag is raised.

## Test plan
- R-type add (0110011), zero-wait memory: FETCH→DECODE→EXECUTE→WB in 4 cycles. `alu_op`=10 in cycle 3. `reg_write`=1, `wb_sel`=00 and `pc_sel`=00 in cycle 4. `instret`=1.
- LOAD with `mem_ready` low for 2 cycles in MEM: 7 cycles total. `mem_req`=1 and `addr_sel`=1 held for 3 cycles. `wb_sel`=01 in WB.
- BRANCH with `branch_taken`=1, then repeated with 0: both retire in 3 cycles. `pc_sel`=01 in the first case and 00 in the second. `reg_write` never asserts.
- STORE then JAL back-to-back: `mem_we`=1 only in the store's MEM cycle. JAL WB gives `wb_sel`=10, `pc_sel`=10. `instret`=2 after 8 cycles.
- Illegal opcode 1111111: TRAP entered after DECODE. `illegal`=1 and `mem_req`=0 held for 20+ cycles. Reset clears `illegal`, and `mem_req`=1 the cycle after release.
- Reset asserted during MEM of a load: all outputs 0 in the same cycle. `instret` unchanged at reset value 0. FETCH resumes after release.
